// File: rtl/dma_ctrl_pkg.sv
// Shared register map, bit positions and types for the DMA channel controller.
package dma_ctrl_pkg;

  localparam int unsigned DESC_ADDR_W = 64;
  localparam int unsigned DESC_LEN_W  = 32;
  localparam int unsigned DONE_W      = 16;

  localparam logic [11:0] CH_STRIDE    = 12'h020;
  localparam logic [11:0] REG_ADDR     = 12'h000;
  localparam logic [11:0] REG_LEN      = 12'h008;
  localparam logic [11:0] REG_CTRL     = 12'h010;
  localparam logic [11:0] REG_STATUS   = 12'h018;
  localparam logic [11:0] REG_IRQ_EN   = 12'h800;
  localparam logic [11:0] REG_IRQ_PEND = 12'h808;
  localparam logic [11:0] REG_INFO     = 12'h810;

  localparam int unsigned CTRL_PUSH    = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_EMPTY    = 2;
  localparam int unsigned STAT_OVF      = 3;
  localparam int unsigned STAT_ZLEN     = 4;
  localparam int unsigned STAT_CNT_LSB  = 8;
  localparam int unsigned STAT_DONE_LSB = 16;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [DESC_LEN_W-1:0]  len;
  } dma_desc_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/dma_desc_fifo.sv
// Per-channel descriptor queue; flush empties it and takes priority over push.
module dma_desc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 64,
  parameter int unsigned LW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [AW-1:0]            in_addr,
  input  logic [LW-1:0]            in_len,
  output logic [AW-1:0]            head_addr,
  output logic [LW-1:0]            head_len,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [LW-1:0]    mem_len  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_len[wr_ptr]  <= in_len;
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_len  = mem_len[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/dma_chan_ctrl.sv
// MMIO control/status for N DMA channels: descriptor queues, per-channel
// start/done FSM, completion counters and a maskable interrupt.
module dma_chan_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 32,
  parameter logic [63:0] BASE   = 64'h4000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              cpu_addr,
  input  logic [63:0]              cpu_wdata,
  input  logic                     cpu_we,
  output logic                     cpu_sel,
  output logic [63:0]              cpu_rdata,
  output logic [N_CH-1:0]          eng_start_valid,
  input  logic [N_CH-1:0]          eng_start_ready,
  output logic [N_CH*ADDR_W-1:0]   eng_addr,
  output logic [N_CH*LEN_W-1:0]    eng_len,
  input  logic [N_CH-1:0]          eng_done,
  output logic                     irq
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [11:0] off;
  logic [3:0]  ch_idx;
  logic [4:0]  reg_off;
  logic        wr;
  logic        ch_hit;
  logic        pend_wr;

  logic [N_CH-1:0]        irq_en;
  logic [N_CH-1:0]        irq_pend;
  logic [N_CH-1:0]        done_evt;
  logic [N_CH-1:0][63:0]  ch_rdata;

  assign cpu_sel = ((cpu_addr & ~64'hFFF) == BASE);
  assign off     = cpu_addr[11:0];
  assign wr      = cpu_we && cpu_sel;
  assign ch_hit  = (off < 12'(N_CH * CH_STRIDE)) && (off[2:0] == 3'd0);
  assign ch_idx  = off[8:5];
  assign reg_off = off[4:0];
  assign pend_wr = wr && (off == REG_IRQ_PEND);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic              sel;
    logic              ctrl_wr;
    logic              push_req;
    logic              flush_req;
    logic              clr_req;
    logic              push_ok;
    logic              pop;
    logic              len_zero;
    logic              start_valid_c;
    logic              done_c;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              zlen;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] stage_addr;
    logic [LEN_W-1:0]  stage_len;
    logic [ADDR_W-1:0] head_addr;
    logic [LEN_W-1:0]  head_len;
    logic [DONE_W-1:0] done_cnt;
    logic [63:0]       rdata;
    ch_state_e         state_q;
    ch_state_e         state_d;

    assign sel       = ch_hit && (ch_idx == 4'(c));
    assign ctrl_wr   = wr && sel && (reg_off == REG_CTRL[4:0]);
    assign push_req  = ctrl_wr && cpu_wdata[CTRL_PUSH];
    assign flush_req = ctrl_wr && cpu_wdata[CTRL_FLUSH];
    assign clr_req   = ctrl_wr && cpu_wdata[CTRL_CLR_ERR];
    assign len_zero  = (stage_len == '0);
    assign pop       = start_valid_c && eng_start_ready[c];
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign push_ok   = push_req && !flush_req && !len_zero && (!full || pop);

    always_comb begin
      state_d       = state_q;
      start_valid_c = 1'b0;
      done_c        = 1'b0;
      case (state_q)
        CH_IDLE: begin
          start_valid_c = !empty;
          if (start_valid_c && eng_start_ready[c]) state_d = CH_RUN;
        end
        CH_RUN: begin
          if (eng_done[c]) begin
            done_c  = 1'b1;
            state_d = CH_IDLE;
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= CH_IDLE;
        stage_addr <= '0;
        stage_len  <= '0;
        ovf        <= 1'b0;
        zlen       <= 1'b0;
        done_cnt   <= '0;
      end else begin
        state_q <= state_d;
        if (wr && sel && (reg_off == REG_ADDR[4:0])) stage_addr <= ADDR_W'(cpu_wdata);
        if (wr && sel && (reg_off == REG_LEN[4:0]))  stage_len  <= LEN_W'(cpu_wdata);
        ovf  <= (ovf && !clr_req) || (push_req && !flush_req && !len_zero && full && !pop);
        zlen <= (zlen && !clr_req) || (push_req && !flush_req && len_zero);
        if (done_c) done_cnt <= done_cnt + DONE_W'(1);
      end
    end

    dma_desc_fifo #(
      .DEPTH (DEPTH),
      .AW    (ADDR_W),
      .LW    (LEN_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_ok),
      .pop       (pop),
      .flush     (flush_req),
      .in_addr   (stage_addr),
      .in_len    (stage_len),
      .head_addr (head_addr),
      .head_len  (head_len),
      .full      (full),
      .empty     (empty),
      .count     (count)
    );

    always_comb begin
      rdata = '0;
      case (reg_off)
        REG_ADDR[4:0]:   rdata = 64'(stage_addr);
        REG_LEN[4:0]:    rdata = 64'(stage_len);
        REG_STATUS[4:0]: rdata = {32'd0, done_cnt, 8'(count), 3'd0,
                                  zlen, ovf, empty, full, (state_q == CH_RUN)};
        default:         rdata = '0;
      endcase
    end

    assign ch_rdata[c]                    = rdata;
    assign done_evt[c]                    = done_c;
    assign eng_start_valid[c]             = start_valid_c;
    assign eng_addr[c*ADDR_W +: ADDR_W]   = head_addr;
    assign eng_len[c*LEN_W +: LEN_W]      = head_len;
  end

  // A completion in the same cycle as a W1C keeps the pending bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en   <= '0;
      irq_pend <= '0;
    end else begin
      if (wr && (off == REG_IRQ_EN)) irq_en <= cpu_wdata[N_CH-1:0];
      irq_pend <= (irq_pend & ~(pend_wr ? cpu_wdata[N_CH-1:0] : '0)) | done_evt;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (cpu_sel) begin
      if (ch_hit) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (ch_idx == 4'(c)) cpu_rdata = ch_rdata[c];
        end
      end else if (off == REG_IRQ_EN) begin
        cpu_rdata = 64'(irq_en);
      end else if (off == REG_IRQ_PEND) begin
        cpu_rdata = 64'(irq_pend);
      end else if (off == REG_INFO) begin
        cpu_rdata = 64'({8'(DEPTH), 8'(N_CH)});
      end
    end
  end

  assign irq = |(irq_pend & irq_en);

endmodule
